// File: rtl/gsc_pkg.sv
// Shared types and default constants for the glitch sequence checker.
// Optional feature macro: GSC_STICKY_ERR_EN (see glitch_seq_checker.sv).
package gsc_pkg;

  typedef enum logic [1:0] {
    INIT,
    SEARCH,
    TRACK
  } gsc_state_e;

  typedef enum logic [1:0] {
    STEP_INC,
    STEP_DEC,
    STEP_BAD
  } gsc_step_e;

  localparam int GSC_DATA_W       = 8;
  localparam int GSC_INC_STEP     = 2;
  localparam int GSC_DEC_STEP     = 5;
  localparam int GSC_PERIOD       = 4;
  localparam int GSC_LOCK_PERIODS = 2;
  localparam int GSC_ERR_W        = 8;

endpackage

// File: rtl/glitch_seq_checker_if.sv
// Sample stream in, lock/error status out.
// master drives samples, slave is the checker.
interface gsc_if #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_vld;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
  logic              err_sticky;
  logic [1:0]        phase;

  modport master (
    output sample_in,
    output sample_vld,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  err_sticky,
    input  phase
  );

  modport slave (
    input  sample_in,
    input  sample_vld,
    output locked,
    output err_pulse,
    output err_count,
    output err_sticky,
    output phase
  );

endinterface

// File: rtl/gsc_step_classifier.sv
// Holds the previous sample and classifies the modulo step
// between it and the current sample.
module gsc_step_classifier
  import gsc_pkg::*;
#(
  parameter int DATA_W   = GSC_DATA_W,
  parameter int INC_STEP = GSC_INC_STEP,
  parameter int DEC_STEP = GSC_DEC_STEP
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  output gsc_step_e         step_cls,
  output logic              prev_valid
);

  localparam logic [DATA_W-1:0] INC_V = DATA_W'(INC_STEP);
  localparam logic [DATA_W-1:0] DEC_V = -DATA_W'(DEC_STEP);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0] diff;

  // prev follows every valid sample; invalid cycles drop history
  always_comb begin
    prev_d       = sample_vld ? sample_in : prev_q;
    prev_valid_d = sample_vld;
  end

  // prev register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // modulo step classification
  always_comb begin
    diff     = sample_in - prev_q;
    step_cls = STEP_BAD;
    if (diff == INC_V)
      step_cls = STEP_INC;
    else if (diff == DEC_V)
      step_cls = STEP_DEC;
  end

  assign prev_valid = prev_valid_q;

endmodule

// File: rtl/glitch_seq_checker.sv
// Phase-locking monitor for the strobe-driven counter stream.
// Define GSC_STICKY_ERR_EN to get a first-error sticky flag.
module glitch_seq_checker
  import gsc_pkg::*;
#(
  parameter int DATA_W       = GSC_DATA_W,
  parameter int INC_STEP     = GSC_INC_STEP,
  parameter int DEC_STEP     = GSC_DEC_STEP,
  parameter int PERIOD       = GSC_PERIOD,
  parameter int LOCK_PERIODS = GSC_LOCK_PERIODS,
  parameter int ERR_W        = GSC_ERR_W
) (
  input logic clk_in,
  input logic rst,
  gsc_if.slave bus
);

  localparam int PC_W = $clog2(LOCK_PERIODS + 1);
  localparam logic [1:0]      LAST_PH = 2'(PERIOD - 1);
  localparam logic [PC_W-1:0] LOCK_PC = PC_W'(LOCK_PERIODS);

  gsc_step_e  step_cls;
  logic       prev_valid;

  gsc_state_e       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [PC_W-1:0]  period_cnt_q, period_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  gsc_step_classifier #(
    .DATA_W   (DATA_W),
    .INC_STEP (INC_STEP),
    .DEC_STEP (DEC_STEP)
  ) u_cls (
    .clk_in     (clk_in),
    .rst        (rst),
    .sample_in  (bus.sample_in),
    .sample_vld (bus.sample_vld),
    .step_cls   (step_cls),
    .prev_valid (prev_valid)
  );

  // next state, phase tracking and error detection
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    period_cnt_d = period_cnt_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    if (!bus.sample_vld) begin
      state_d      = INIT;
      phase_d      = '0;
      period_cnt_d = '0;
    end else begin
      unique case (state_q)
        INIT: state_d = SEARCH;
        SEARCH: begin
          if (prev_valid && step_cls == STEP_DEC) begin
            state_d      = TRACK;
            phase_d      = '0;
            period_cnt_d = '0;
          end
        end
        TRACK: begin
          if (phase_q == LAST_PH && step_cls == STEP_DEC) begin
            phase_d = '0;
            if (period_cnt_q != LOCK_PC)
              period_cnt_d = period_cnt_q + 1'b1;
          end else if (phase_q != LAST_PH && step_cls == STEP_INC) begin
            phase_d = phase_q + 1'b1;
          end else begin
            err_pulse_d  = 1'b1;
            if (err_count_q != '1)
              err_count_d = err_count_q + 1'b1;
            state_d      = SEARCH;
            phase_d      = '0;
            period_cnt_d = '0;
          end
        end
        default: begin
          state_d      = INIT;
          phase_d      = '0;
          period_cnt_d = '0;
        end
      endcase
    end
    locked_d = (state_d == TRACK) && (period_cnt_d == LOCK_PC);
  end

  // state and status registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= INIT;
      phase_q      <= '0;
      period_cnt_q <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      period_cnt_q <= period_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

`ifdef GSC_STICKY_ERR_EN
  logic err_sticky_q, err_sticky_d;

  // latch the first error until reset
  always_comb begin
    err_sticky_d = err_sticky_q | err_pulse_d;
  end

  // sticky register
  always_ff @(posedge clk_in) begin
    if (rst) err_sticky_q <= 1'b0;
    else     err_sticky_q <= err_sticky_d;
  end

  assign bus.err_sticky = err_sticky_q;
`else
  assign bus.err_sticky = 1'b0;
`endif

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.phase     = phase_q;

endmodule

// File: tb/tb_glitch_seq_checker.sv
// Directed self-checking bench for glitch_seq_checker.
// Honors GSC_STICKY_ERR_EN for the sticky flag expectation.
module tb_glitch_seq_checker;

`ifdef GSC_STICKY_ERR_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] cur;

  gsc_if #(.DATA_W(8), .ERR_W(8)) bus ();

  glitch_seq_checker dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // apply one sample, settle 1 time unit past the edge
  task automatic drive(input logic [7:0] v, input logic vld);
    bus.sample_in  = v;
    bus.sample_vld = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic inc();
    cur = cur + 8'd2;
    drive(cur, 1'b1);
  endtask

  task automatic dec();
    cur = cur - 8'd5;
    drive(cur, 1'b1);
  endtask

  task automatic bad();
    cur = cur + 8'h40;
    drive(cur, 1'b1);
  endtask

  logic [7:0] seq1 [13];
  logic [1:0] ph1  [13];

  initial begin
    checks = 0;
    errors = 0;
    seq1 = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd1, 8'd3, 8'd5,
             8'd7, 8'd2, 8'd4, 8'd6, 8'd8, 8'd3};
    ph1  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2,
             2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    bus.sample_in  = '0;
    bus.sample_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_pulse", 32'(bus.err_pulse), 0);
    chk("rst_count", 32'(bus.err_count), 0);
    chk("rst_sticky", 32'(bus.err_sticky), 0);
    chk("rst_phase", 32'(bus.phase), 0);
    rst = 1'b0;

    // acquire and lock
    for (int i = 0; i < 13; i++) begin
      drive(seq1[i], 1'b1);
      chk($sformatf("t1_phase%0d", i), 32'(bus.phase), 32'(ph1[i]));
      chk($sformatf("t1_lock%0d", i), 32'(bus.locked),
          (i == 12) ? 32'd1 : 32'd0);
    end
    chk("t1_count", 32'(bus.err_count), 0);
    chk("t1_pulse", 32'(bus.err_pulse), 0);

    // bad sample while locked
    drive(8'h50, 1'b1);
    chk("t2_pulse", 32'(bus.err_pulse), 1);
    chk("t2_count", 32'(bus.err_count), 1);
    chk("t2_locked", 32'(bus.locked), 0);
    chk("t2_phase", 32'(bus.phase), 0);
    chk("t2_sticky", 32'(bus.err_sticky), 32'(STK));
    cur = 8'h50;
    dec();
    chk("t2_pulse_gone", 32'(bus.err_pulse), 0);
    inc();
    chk("t2_retrack", 32'(bus.phase), 1);
    inc(); inc(); dec();
    inc(); inc(); inc(); dec();
    chk("t2_relock", 32'(bus.locked), 1);
    chk("t2_count_hold", 32'(bus.err_count), 1);

    // valid drop while locked
    drive(8'h33, 1'b0);
    chk("t4_locked", 32'(bus.locked), 0);
    chk("t4_count", 32'(bus.err_count), 1);
    chk("t4_pulse", 32'(bus.err_pulse), 0);
    chk("t4_phase", 32'(bus.phase), 0);
    cur = 8'hFF;
    drive(cur, 1'b1);
    dec();
    chk("t4_track", 32'(bus.phase), 0);
    inc(); inc(); inc(); dec();
    chk("t4_one_period", 32'(bus.locked), 0);
    inc(); inc(); inc();
    chk("t4_at_01", 32'(cur), 32'h01);
    dec();
    chk("t4_relock", 32'(bus.locked), 1);
    chk("t4_count_hold", 32'(bus.err_count), 1);

    // wrap through 0xFC,0xFE,0x00,0x02,0xFD
    for (int i = 0; i < 4; i++) begin
      if (i < 3) inc();
      else       dec();
      chk($sformatf("t3_pulse%0d", i), 32'(bus.err_pulse), 0);
      chk($sformatf("t3_lock%0d", i), 32'(bus.locked), 1);
      chk($sformatf("t3_phase%0d", i), 32'(bus.phase),
          (i < 3) ? 32'(i + 1) : 32'd0);
    end
    chk("t3_end", 32'(cur), 32'hFD);

    // error saturation
    bad();
    chk("t5_first", 32'(bus.err_count), 2);
    for (int i = 1; i <= 300; i++) begin
      dec();
      bad();
      if (i == 252)
        chk("t5_254", 32'(bus.err_count), 254);
      if (i == 253)
        chk("t5_255", 32'(bus.err_count), 255);
    end
    chk("t5_sat", 32'(bus.err_count), 255);
    chk("t5_pulse", 32'(bus.err_pulse), 1);
    chk("t5_sticky", 32'(bus.err_sticky), 32'(STK));

    // reset mid-track with three errors logged
    rst = 1'b1;
    drive(8'h00, 1'b0);
    rst = 1'b0;
    chk("t6_clear", 32'(bus.err_count), 0);
    cur = 8'h10;
    drive(cur, 1'b1);
    dec(); bad();
    dec(); bad();
    dec(); bad();
    dec(); inc();
    chk("t6_count3", 32'(bus.err_count), 3);
    chk("t6_phase1", 32'(bus.phase), 1);
    rst = 1'b1;
    inc();
    rst = 1'b0;
    chk("t6_locked", 32'(bus.locked), 0);
    chk("t6_pulse", 32'(bus.err_pulse), 0);
    chk("t6_count", 32'(bus.err_count), 0);
    chk("t6_sticky", 32'(bus.err_sticky), 0);
    chk("t6_phase", 32'(bus.phase), 0);
    dec();
    chk("t6_init_no_track", 32'(bus.phase), 0);
    inc();
    chk("t6_search_no_track", 32'(bus.phase), 0);
    dec();
    inc();
    chk("t6_track_again", 32'(bus.phase), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
